// File: rtl/cpu_core_if.sv
// Bus bundle between the audio sequencer core and its host side:
// instruction/audio bus, synth strobes and DMA handshake.
interface cpu_core_if #(
    parameter int INW   = 512,
    parameter int ADDRW = 32,
    parameter int IMMW  = 11
);
    logic [INW-1:0]   common_data_bus_in;
    logic             instr_write_en;
    logic             rd_valid;
    logic             dma_ready;
    logic             tx_done;
    logic             cache_stall;
    logic [1:0]       op;
    logic [IMMW-1:0]  imm;
    logic             syn;
    logic             set_en;
    logic             set_freq;
    logic [INW-1:0]   audio_out;
    logic             audio_valid;
    logic [ADDRW-1:0] mem_address;
    logic             mem_write_en;

    modport master (
        output common_data_bus_in, instr_write_en, rd_valid,
        output dma_ready, tx_done,
        input  cache_stall, op, imm, syn, set_en, set_freq,
        input  audio_out, audio_valid, mem_address, mem_write_en
    );

    modport slave (
        input  common_data_bus_in, instr_write_en, rd_valid,
        input  dma_ready, tx_done,
        output cache_stall, op, imm, syn, set_en, set_freq,
        output audio_out, audio_valid, mem_address, mem_write_en
    );
endinterface

// File: rtl/cpu_core.sv
// Line-buffered sequencer for the audio-synthesis datapath.
// Executes 32 16-bit instructions per loaded line, one per cycle.
module cpu_core #(
    parameter int INW    = 512,
    parameter int ADDRW  = 32,
    parameter int IMMW   = 11,
    parameter int INSTRW = 16
) (
    input logic      clk,
    input logic      rst_n,
    cpu_core_if.slave bus
);
    localparam int NUMINSTRUCTIONS = INW / INSTRW;
    localparam int PCW = $clog2(NUMINSTRUCTIONS);
    localparam int OPCW = INSTRW - IMMW;

    typedef enum logic [2:0] {
        STALL, EXEC, WAIT_RD, WAIT_DMA, WAIT_TX, HALT
    } state_t;

    typedef enum logic [OPCW-1:0] {
        OP_NOP     = 5'd0,
        OP_HALT    = 5'd1,
        OP_SETOP   = 5'd2,
        OP_SETFREQ = 5'd3,
        OP_SYN     = 5'd4,
        OP_LDA     = 5'd5,
        OP_ADDA    = 5'd6,
        OP_WR      = 5'd7,
        OP_JMP     = 5'd8
    } opc_t;

    state_t           state_q, state_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic [INW-1:0]   line_q;
    logic [1:0]       op_q, op_d;
    logic [IMMW-1:0]  imm_q, imm_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [INW-1:0]   audio_q, audio_d;
    logic             syn_q, syn_d;
    logic             set_en_q, set_en_d;
    logic             set_freq_q, set_freq_d;
    logic             aval_q, aval_d;
    logic             wr_q, wr_d;
    logic             adv;

    logic [INSTRW-1:0] instr;
    logic [OPCW-1:0]   opc;
    logic [IMMW-1:0]   immv;

    // Current instruction selected from the line buffer by pc
    always_comb begin
        instr = line_q[int'(pc_q) * INSTRW +: INSTRW];
        opc   = instr[INSTRW-1:IMMW];
        immv  = instr[IMMW-1:0];
    end

    // Line buffer has no reset: its contents only matter after a load
    always_ff @(posedge clk) begin
        if (bus.instr_write_en) line_q <= bus.common_data_bus_in;
    end

    // Control state and program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STALL;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Registered synth controls, DMA address, audio capture and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            imm_q      <= '0;
            addr_q     <= '0;
            audio_q    <= '0;
            syn_q      <= 1'b0;
            set_en_q   <= 1'b0;
            set_freq_q <= 1'b0;
            aval_q     <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            op_q       <= op_d;
            imm_q      <= imm_d;
            addr_q     <= addr_d;
            audio_q    <= audio_d;
            syn_q      <= syn_d;
            set_en_q   <= set_en_d;
            set_freq_q <= set_freq_d;
            aval_q     <= aval_d;
            wr_q       <= wr_d;
        end
    end

    // Next state, execute and wait handling; a line load overrides all
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        imm_d      = imm_q;
        addr_d     = addr_q;
        audio_d    = audio_q;
        syn_d      = 1'b0;
        set_en_d   = 1'b0;
        set_freq_d = 1'b0;
        aval_d     = 1'b0;
        wr_d       = 1'b0;
        adv        = 1'b0;
        if (bus.instr_write_en) begin
            pc_d    = '0;
            state_d = EXEC;
        end else begin
            case (state_q)
                EXEC: begin
                    case (opc)
                        OP_HALT: state_d = HALT;
                        OP_SETOP: begin
                            op_d     = immv[1:0];
                            imm_d    = immv;
                            set_en_d = 1'b1;
                            adv      = 1'b1;
                        end
                        OP_SETFREQ: begin
                            imm_d      = immv;
                            set_freq_d = 1'b1;
                            adv        = 1'b1;
                        end
                        OP_SYN: begin
                            imm_d   = immv;
                            syn_d   = 1'b1;
                            state_d = WAIT_RD;
                        end
                        OP_LDA: begin
                            addr_d = ADDRW'(immv);
                            adv    = 1'b1;
                        end
                        OP_ADDA: begin
                            addr_d = addr_q + {{(ADDRW-IMMW){immv[IMMW-1]}}, immv};
                            adv    = 1'b1;
                        end
                        OP_WR:  state_d = WAIT_DMA;
                        OP_JMP: pc_d = immv[PCW-1:0];
                        default: adv = 1'b1;
                    endcase
                end
                WAIT_RD: begin
                    if (bus.rd_valid) begin
                        audio_d = bus.common_data_bus_in;
                        aval_d  = 1'b1;
                        adv     = 1'b1;
                    end
                end
                WAIT_DMA: begin
                    if (bus.dma_ready) begin
                        wr_d    = 1'b1;
                        state_d = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (bus.tx_done) adv = 1'b1;
                end
                default: ;
            endcase
            // Line is consumed after its last slot; no wrap to pc 0
            if (adv) begin
                pc_d    = pc_q + PCW'(1);
                state_d = (pc_q == PCW'(NUMINSTRUCTIONS - 1)) ? STALL : EXEC;
            end
        end
    end

    assign bus.cache_stall  = (state_q == STALL);
    assign bus.op           = op_q;
    assign bus.imm          = imm_q;
    assign bus.syn          = syn_q;
    assign bus.set_en       = set_en_q;
    assign bus.set_freq     = set_freq_q;
    assign bus.audio_out    = audio_q;
    assign bus.audio_valid  = aval_q;
    assign bus.mem_address  = addr_q;
    assign bus.mem_write_en = wr_q;
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: strobe events go through a scoreboard
// queue checked by a monitor; levels are checked inline.
module tb_cpu_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [4:0] S_SYN  = 5'b10000;
    localparam logic [4:0] S_SETE = 5'b01000;
    localparam logic [4:0] S_SETF = 5'b00100;
    localparam logic [4:0] S_AVAL = 5'b00010;
    localparam logic [4:0] S_WR   = 5'b00001;

    localparam logic [4:0] NOP  = 5'd0, HLT = 5'd1, SETOP = 5'd2;
    localparam logic [4:0] SETF = 5'd3, SYN = 5'd4, LDA = 5'd5;
    localparam logic [4:0] ADDA = 5'd6, WR = 5'd7, JMP = 5'd8;

    typedef struct {
        logic [4:0]   stb;
        logic [1:0]   op;
        logic [10:0]  imm;
        logic [31:0]  addr;
        logic [511:0] audio;
    } ev_t;

    ev_t exp_q[$];
    logic [511:0] a5 = {64{8'hA5}};
    logic [511:0] l;

    cpu_core_if bus_if ();

    cpu_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] i);
        return {o, i};
    endfunction

    function automatic logic [511:0] mk(input logic [15:0] w0, w1, w2, w3);
        logic [511:0] r;
        r = '0;
        r[15:0]  = w0;
        r[31:16] = w1;
        r[47:32] = w2;
        r[63:48] = w3;
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h need=%h", nm, act, req);
        end
    endtask

    task automatic expect_ev(input logic [4:0] s, input logic [1:0] o,
                             input logic [10:0] i, input logic [31:0] a,
                             input logic [511:0] au);
        ev_t e;
        e.stb = s; e.op = o; e.imm = i; e.addr = a; e.audio = au;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [511:0] ln);
        bus_if.common_data_bus_in = ln;
        bus_if.instr_write_en = 1'b1;
        cyc(1);
        bus_if.instr_write_en = 1'b0;
        bus_if.common_data_bus_in = '0;
    endtask

    // Monitor: every strobe cycle must match the oldest expected event
    initial begin
        ev_t g, e;
        int n = 0;
        forever begin
            @(negedge clk);
            g.stb = {bus_if.syn, bus_if.set_en, bus_if.set_freq,
                     bus_if.audio_valid, bus_if.mem_write_en};
            if (g.stb != 5'b0) begin
                g.op = bus_if.op; g.imm = bus_if.imm;
                g.addr = bus_if.mem_address; g.audio = bus_if.audio_out;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ev%0d unexpected stb=%b", n, g.stb);
                end else begin
                    e = exp_q.pop_front();
                    if (g.stb !== e.stb || g.op !== e.op || g.imm !== e.imm ||
                        g.addr !== e.addr || g.audio !== e.audio) begin
                        failures++;
                        $display("FAIL ev%0d got stb=%b op=%0d imm=%h addr=%h aud=%h need stb=%b op=%0d imm=%h addr=%h aud=%h",
                                 n, g.stb, g.op, g.imm, g.addr, g.audio[31:0],
                                 e.stb, e.op, e.imm, e.addr, e.audio[31:0]);
                    end
                end
                n++;
            end
        end
    end

    initial begin
        bus_if.common_data_bus_in = '0;
        bus_if.instr_write_en = 1'b0;
        bus_if.rd_valid = 1'b0;
        bus_if.dma_ready = 1'b0;
        bus_if.tx_done = 1'b0;
        cyc(3);
        chk("rst_stall", 64'(bus_if.cache_stall), 64'd1);
        chk("rst_ctl", {19'd0, bus_if.op, bus_if.imm, bus_if.mem_address}, 64'd0);
        chk("rst_audio", 64'(|bus_if.audio_out), 64'd0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_stall", 64'(bus_if.cache_stall), 64'd1);

        // All-NOP line: runs 32 cycles then stalls, no strobes
        load('0);
        chk("nop_run", 64'(bus_if.cache_stall), 64'd0);
        cyc(31);
        chk("nop_last", 64'(bus_if.cache_stall), 64'd0);
        cyc(1);
        chk("nop_stall", 64'(bus_if.cache_stall), 64'd1);

        // SETOP, SETFREQ, HALT
        expect_ev(S_SETE, 2'd2, 11'h002, 32'd0, '0);
        expect_ev(S_SETF, 2'd2, 11'h1B8, 32'd0, '0);
        load(mk(ins(SETOP, 11'h002), ins(SETF, 11'h1B8), ins(HLT, 0), ins(NOP, 0)));
        cyc(6);
        chk("halt_stall", 64'(bus_if.cache_stall), 64'd0);
        chk("set_op", 64'(bus_if.op), 64'd2);
        chk("set_imm", 64'(bus_if.imm), 64'h1B8);

        // SYN then audio capture, then resume to end of line
        expect_ev(S_SYN, 2'd2, 11'd5, 32'd0, '0);
        load(mk(ins(SYN, 11'd5), 16'd0, 16'd0, 16'd0));
        cyc(4);
        chk("syn_aud_hold", bus_if.audio_out[63:0], 64'd0);
        expect_ev(S_AVAL, 2'd2, 11'd5, 32'd0, a5);
        bus_if.rd_valid = 1'b1;
        bus_if.common_data_bus_in = a5;
        cyc(1);
        bus_if.rd_valid = 1'b0;
        bus_if.common_data_bus_in = '0;
        cyc(30);
        chk("syn_run", 64'(bus_if.cache_stall), 64'd0);
        cyc(1);
        chk("syn_stall", 64'(bus_if.cache_stall), 64'd1);

        // LDA, ADDA -1, WR, HALT with stray events during WAIT_TX
        load(mk(ins(LDA, 11'h100), ins(ADDA, 11'h7FF), ins(WR, 0), ins(HLT, 0)));
        cyc(3);
        chk("adda_addr", 64'(bus_if.mem_address), 64'hFF);
        cyc(2);
        expect_ev(S_WR, 2'd2, 11'd5, 32'hFF, a5);
        bus_if.dma_ready = 1'b1;
        cyc(1);
        bus_if.dma_ready = 1'b0;
        bus_if.rd_valid = 1'b1;
        bus_if.common_data_bus_in = {64{8'h3C}};
        cyc(1);
        bus_if.rd_valid = 1'b0;
        bus_if.common_data_bus_in = '0;
        bus_if.dma_ready = 1'b1;
        cyc(1);
        bus_if.dma_ready = 1'b0;
        chk("tx_aud_hold", bus_if.audio_out[63:0], a5[63:0]);
        chk("tx_wait", 64'(bus_if.cache_stall), 64'd0);
        bus_if.tx_done = 1'b1;
        cyc(1);
        bus_if.tx_done = 1'b0;
        cyc(3);
        chk("wr_halt", 64'(bus_if.cache_stall), 64'd0);
        chk("wr_addr", 64'(bus_if.mem_address), 64'hFF);

        // JMP 0 loop, then reload restarts at pc 0
        load(mk(ins(JMP, 0), 16'd0, 16'd0, 16'd0));
        cyc(40);
        chk("jmp_loop", 64'(bus_if.cache_stall), 64'd0);
        expect_ev(S_SETF, 2'd2, 11'h033, 32'hFF, a5);
        load(mk(ins(SETF, 11'h033), ins(HLT, 0), 16'd0, 16'd0));
        cyc(3);
        chk("reload_imm", 64'(bus_if.imm), 64'h033);

        // Load beats rd_valid in the same cycle
        expect_ev(S_SYN, 2'd2, 11'd7, 32'hFF, a5);
        load(mk(ins(SYN, 11'd7), ins(HLT, 0), 16'd0, 16'd0));
        cyc(2);
        expect_ev(S_SETE, 2'd1, 11'd1, 32'hFF, a5);
        l = mk(ins(SETOP, 11'd1), ins(HLT, 0), 16'd0, 16'd0);
        bus_if.common_data_bus_in = l;
        bus_if.instr_write_en = 1'b1;
        bus_if.rd_valid = 1'b1;
        cyc(1);
        bus_if.instr_write_en = 1'b0;
        bus_if.rd_valid = 1'b0;
        bus_if.common_data_bus_in = '0;
        cyc(3);
        chk("prio_aud", bus_if.audio_out[63:0], a5[63:0]);
        chk("prio_op", 64'(bus_if.op), 64'd1);

        // Async reset while in WAIT_TX
        expect_ev(S_WR, 2'd1, 11'd1, 32'hFF, a5);
        load(mk(ins(WR, 0), ins(HLT, 0), 16'd0, 16'd0));
        cyc(1);
        bus_if.dma_ready = 1'b1;
        cyc(1);
        bus_if.dma_ready = 1'b0;
        cyc(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 64'(bus_if.cache_stall), 64'd1);
        chk("arst_ctl", {19'd0, bus_if.op, bus_if.imm, bus_if.mem_address}, 64'd0);
        chk("arst_audio", 64'(|bus_if.audio_out), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_stall", 64'(bus_if.cache_stall), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
